// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared opcodes, ALU/branch encodings and the per-stage control
//               bundle for the 5-stage RV32I pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int c_reg_aw = 5;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6
    } br_type_e;

    localparam logic [1:0] c_m2r_alu   = 2'b00;
    localparam logic [1:0] c_m2r_mem   = 2'b01;
    localparam logic [1:0] c_m2r_pc4   = 2'b10;
    localparam logic [1:0] c_m2r_pcimm = 2'b11;

    typedef struct packed {
        alu_op_e               alu_op;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic [1:0]            mem_to_reg;
        br_type_e              br_type;
        logic                  jump;
        logic                  jalr;
        logic [c_reg_aw-1:0]   rd;
        logic [c_reg_aw-1:0]   rs1;
        logic [c_reg_aw-1:0]   rs2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t c_bubble = '{
        alu_op:     ALU_ADD,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: c_m2r_alu,
        br_type:    BR_NONE,
        jump:       1'b0,
        jalr:       1'b0,
        rd:         '0,
        rs1:        '0,
        rs2:        '0
    };

    // funct7[5] selects SUB only for register-register ops; shifts use it in both.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       allow_sub);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_inst_decode.sv
// ============================================================================
// Module      : pipe_ctrl_inst_decode
// Description : Combinational ID-stage decoder: control bundle, rs-use flags
//               and illegal-instruction detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_inst_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0]  i_inst,
    output ctrl_bundle_t o_bundle,
    output logic         o_use_rs1,
    output logic         o_use_rs2,
    output logic         o_illegal
);

    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [2:0] w_funct3;
    logic       w_alt;
    logic       w_unused;

    assign w_opcode = i_inst[6:0];
    assign w_rd     = i_inst[11:7];
    assign w_funct3 = i_inst[14:12];
    assign w_rs1    = i_inst[19:15];
    assign w_rs2    = i_inst[24:20];
    assign w_alt    = i_inst[30];
    assign w_unused = ^{i_inst[31], i_inst[29:25]};

    always_comb begin
        o_bundle  = c_bubble;
        o_use_rs1 = 1'b0;
        o_use_rs2 = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            c_op_r: begin
                o_bundle.alu_op    = alu_decode(w_funct3, w_alt, 1'b1);
                o_bundle.reg_write = 1'b1;
                o_bundle.rd        = w_rd;
                o_use_rs1          = 1'b1;
                o_use_rs2          = 1'b1;
            end
            c_op_i: begin
                o_bundle.alu_op    = alu_decode(w_funct3, w_alt, 1'b0);
                o_bundle.alu_src   = 1'b1;
                o_bundle.reg_write = 1'b1;
                o_bundle.rd        = w_rd;
                o_use_rs1          = 1'b1;
            end
            c_op_load: begin
                o_bundle.alu_src    = 1'b1;
                o_bundle.mem_read   = 1'b1;
                o_bundle.reg_write  = 1'b1;
                o_bundle.mem_to_reg = c_m2r_mem;
                o_bundle.rd         = w_rd;
                o_use_rs1           = 1'b1;
            end
            c_op_store: begin
                o_bundle.alu_src   = 1'b1;
                o_bundle.mem_write = 1'b1;
                o_use_rs1          = 1'b1;
                o_use_rs2          = 1'b1;
            end
            c_op_branch: begin
                o_use_rs1 = 1'b1;
                o_use_rs2 = 1'b1;
                case (w_funct3)
                    3'b000:  o_bundle.br_type = BR_EQ;
                    3'b001:  o_bundle.br_type = BR_NE;
                    3'b100:  o_bundle.br_type = BR_LT;
                    3'b101:  o_bundle.br_type = BR_GE;
                    3'b110:  o_bundle.br_type = BR_LTU;
                    3'b111:  o_bundle.br_type = BR_GEU;
                    default: o_illegal        = 1'b1;
                endcase
            end
            c_op_jal: begin
                o_bundle.jump       = 1'b1;
                o_bundle.reg_write  = 1'b1;
                o_bundle.mem_to_reg = c_m2r_pc4;
                o_bundle.rd         = w_rd;
            end
            c_op_jalr: begin
                o_bundle.jump       = 1'b1;
                o_bundle.jalr       = 1'b1;
                o_bundle.alu_src    = 1'b1;
                o_bundle.reg_write  = 1'b1;
                o_bundle.mem_to_reg = c_m2r_pc4;
                o_bundle.rd         = w_rd;
                o_use_rs1           = 1'b1;
            end
            c_op_lui: begin
                o_bundle.alu_op    = ALU_PASSB;
                o_bundle.alu_src   = 1'b1;
                o_bundle.reg_write = 1'b1;
                o_bundle.rd        = w_rd;
            end
            c_op_auipc: begin
                o_bundle.alu_src    = 1'b1;
                o_bundle.reg_write  = 1'b1;
                o_bundle.mem_to_reg = c_m2r_pcimm;
                o_bundle.rd         = w_rd;
            end
            default: o_illegal = 1'b1;
        endcase
        // Unused source fields are zeroed so they can never alias a producer.
        o_bundle.rs1 = o_use_rs1 ? w_rs1 : '0;
        o_bundle.rs2 = o_use_rs2 ? w_rs2 : '0;
    end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : 5-stage RV32I pipeline controller: ID decode, ID/EX..MEM/WB
//               control registers, EX branch resolution, hazards, forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int REG_AW = 5
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_inst,
    input  logic              id_valid,
    input  logic              ex_eq,
    input  logic              ex_lt,
    input  logic              ex_ltu,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic [1:0]        wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        pc_sel,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              illegal_id
);

    ctrl_bundle_t r_ex;
    ctrl_bundle_t r_mem;
    ctrl_bundle_t r_wb;
    ctrl_bundle_t w_id_bundle;
    logic         w_use_rs1;
    logic         w_use_rs2;
    logic         w_illegal;
    logic         w_id_live;
    logic         w_br_taken;
    logic         w_redirect;
    logic         w_ex_hit;
    logic         w_mem_hit;
    logic         w_hazard;
    logic         w_stall;
    logic         w_unused;

    pipe_ctrl_inst_decode u_inst_decode (
        .i_inst    (id_inst),
        .o_bundle  (w_id_bundle),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2),
        .o_illegal (w_illegal)
    );

    assign w_id_live = id_valid & ~w_illegal;

    always_comb begin
        w_br_taken = 1'b0;
        case (r_ex.br_type)
            BR_EQ:   w_br_taken = ex_eq;
            BR_NE:   w_br_taken = ~ex_eq;
            BR_LT:   w_br_taken = ex_lt;
            BR_GE:   w_br_taken = ~ex_lt;
            BR_LTU:  w_br_taken = ex_ltu;
            BR_GEU:  w_br_taken = ~ex_ltu;
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_redirect = w_br_taken | r_ex.jump;

    assign w_ex_hit  = (r_ex.rd != '0) &&
                       ((w_use_rs1 && (r_ex.rd == w_id_bundle.rs1)) ||
                        (w_use_rs2 && (r_ex.rd == w_id_bundle.rs2)));
    assign w_mem_hit = (r_mem.rd != '0) &&
                       ((w_use_rs1 && (r_mem.rd == w_id_bundle.rs1)) ||
                        (w_use_rs2 && (r_mem.rd == w_id_bundle.rs2)));

    function automatic logic [1:0] fwd_sel(input ctrl_bundle_t mem_b,
                                           input ctrl_bundle_t wb_b,
                                           input logic [4:0]   rs);
        if (mem_b.reg_write && (mem_b.rd != '0) && (mem_b.rd == rs)) begin
            return 2'b10;
        end
        if (wb_b.reg_write && (wb_b.rd != '0) && (wb_b.rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign w_hazard = w_id_live & r_ex.mem_read & w_ex_hit;
            assign fwd_a    = fwd_sel(r_mem, r_wb, r_ex.rs1);
            assign fwd_b    = fwd_sel(r_mem, r_wb, r_ex.rs2);
        end else begin : g_no_fwd
            // WB is not checked: the register file writes through to ID reads.
            assign w_hazard = w_id_live &
                              ((r_ex.reg_write & w_ex_hit) | (r_mem.reg_write & w_mem_hit));
            assign fwd_a    = 2'b00;
            assign fwd_b    = 2'b00;
        end
    endgenerate

    // A redirect discards the ID instruction, so any stall it raised is moot.
    assign w_stall = w_hazard & ~w_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= c_bubble;
            r_mem <= c_bubble;
            r_wb  <= c_bubble;
        end else begin
            r_ex  <= (w_id_live && !w_stall && !w_redirect) ? w_id_bundle : c_bubble;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign ex_alu_op     = r_ex.alu_op;
    assign ex_alu_src    = r_ex.alu_src;
    assign mem_read      = r_mem.mem_read;
    assign mem_write     = r_mem.mem_write;
    assign wb_reg_write  = r_wb.reg_write;
    assign wb_mem_to_reg = r_wb.mem_to_reg;
    assign wb_rd         = r_wb.rd;

    assign pc_sel     = rst ? 2'b00 : (r_ex.jalr ? 2'b10 : (w_redirect ? 2'b01 : 2'b00));
    assign flush_id   = w_redirect & ~rst;
    assign stall_if   = w_stall & ~rst;
    assign stall_id   = w_stall & ~rst;
    assign illegal_id = id_valid & w_illegal & ~rst;

    assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl, with one instance
//               using forwarding and one resolving hazards by stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        ex_eq;
    logic        ex_lt;
    logic        ex_ltu;

    logic [3:0] f_ex_alu_op, s_ex_alu_op;
    logic       f_ex_alu_src, s_ex_alu_src;
    logic       f_mem_read, s_mem_read;
    logic       f_mem_write, s_mem_write;
    logic       f_wb_reg_write, s_wb_reg_write;
    logic [1:0] f_wb_mem_to_reg, s_wb_mem_to_reg;
    logic [4:0] f_wb_rd, s_wb_rd;
    logic [1:0] f_pc_sel, s_pc_sel;
    logic       f_stall_if, s_stall_if;
    logic       f_stall_id, s_stall_id;
    logic       f_flush_id, s_flush_id;
    logic [1:0] f_fwd_a, s_fwd_a;
    logic [1:0] f_fwd_b, s_fwd_b;
    logic       f_illegal_id, s_illegal_id;
    logic [24:0] f_all, s_all;

    int total = 0;
    int bad   = 0;

    assign f_all = {f_ex_alu_op, f_ex_alu_src, f_mem_read, f_mem_write, f_wb_reg_write,
                    f_wb_mem_to_reg, f_wb_rd, f_pc_sel, f_stall_if, f_stall_id,
                    f_flush_id, f_fwd_a, f_fwd_b, f_illegal_id};
    assign s_all = {s_ex_alu_op, s_ex_alu_src, s_mem_read, s_mem_write, s_wb_reg_write,
                    s_wb_mem_to_reg, s_wb_rd, s_pc_sel, s_stall_if, s_stall_id,
                    s_flush_id, s_fwd_a, s_fwd_b, s_illegal_id};

    pipe_ctrl #(.FWD_EN(1), .REG_AW(5)) u_dut_fwd (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
        .ex_eq(ex_eq), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
        .ex_alu_op(f_ex_alu_op), .ex_alu_src(f_ex_alu_src),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .wb_reg_write(f_wb_reg_write), .wb_mem_to_reg(f_wb_mem_to_reg), .wb_rd(f_wb_rd),
        .pc_sel(f_pc_sel), .stall_if(f_stall_if), .stall_id(f_stall_id),
        .flush_id(f_flush_id), .fwd_a(f_fwd_a), .fwd_b(f_fwd_b), .illegal_id(f_illegal_id)
    );

    pipe_ctrl #(.FWD_EN(0), .REG_AW(5)) u_dut_stall (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
        .ex_eq(ex_eq), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
        .ex_alu_op(s_ex_alu_op), .ex_alu_src(s_ex_alu_src),
        .mem_read(s_mem_read), .mem_write(s_mem_write),
        .wb_reg_write(s_wb_reg_write), .wb_mem_to_reg(s_wb_mem_to_reg), .wb_rd(s_wb_rd),
        .pc_sel(s_pc_sel), .stall_if(s_stall_if), .stall_id(s_stall_id),
        .flush_id(s_flush_id), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .illegal_id(s_illegal_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] inst, input logic valid);
        id_inst  = inst;
        id_valid = valid;
        ex_eq    = 1'b0;
        ex_lt    = 1'b0;
        ex_ltu   = 1'b0;
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        id_valid = 1'b0;
        id_inst  = 32'h0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        feed(enc_r(7'h00, 5'd3, 5'd2, 5'd1), 1'b1);
        next_cycle();
        next_cycle();
        if (f_all !== 25'h0) begin bad++; $display("FAIL reset_fwd got=%h exp=0", f_all); end
        total++;
        if (s_all !== 25'h0) begin bad++; $display("FAIL reset_stall got=%h exp=0", s_all); end
        total++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (f_wb_reg_write !== (i == 2)) begin
                bad++;
                $display("FAIL reset_wb_latency cycle=%0d got=%b exp=%b", i, f_wb_reg_write, (i == 2));
            end
            total++;
        end
        if (f_wb_rd !== 5'd1) begin bad++; $display("FAIL reset_wb_rd got=%0d exp=1", f_wb_rd); end
        total++;
    endtask

    task automatic test_forwarding;
        do_reset();
        feed(enc_r(7'h00, 5'd3, 5'd2, 5'd1), 1'b1);
        next_cycle();
        feed(enc_r(7'h20, 5'd5, 5'd1, 5'd4), 1'b1);
        if (f_stall_if !== 1'b0) begin bad++; $display("FAIL fwd_no_stall got=%b exp=0", f_stall_if); end
        total++;
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_fwd_a, f_fwd_b} !== 4'b1000) begin
            bad++; $display("FAIL fwd_from_mem got=%b exp=1000", {f_fwd_a, f_fwd_b});
        end
        total++;
        if (f_ex_alu_op !== 4'd1) begin bad++; $display("FAIL sub_alu_op got=%0d exp=1", f_ex_alu_op); end
        total++;

        do_reset();
        feed(enc_r(7'h00, 5'd3, 5'd2, 5'd1), 1'b1);
        next_cycle();
        feed(enc_i(12'd1, 5'd7, 3'b000, 5'd6, 7'b0010011), 1'b1);
        next_cycle();
        feed(enc_r(7'h20, 5'd5, 5'd1, 5'd4), 1'b1);
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_fwd_a, f_fwd_b} !== 4'b0100) begin
            bad++; $display("FAIL fwd_from_wb got=%b exp=0100", {f_fwd_a, f_fwd_b});
        end
        total++;
    endtask

    task automatic test_load_use;
        do_reset();
        feed(enc_i(12'd0, 5'd2, 3'b010, 5'd1, 7'b0000011), 1'b1);
        next_cycle();
        feed(enc_r(7'h00, 5'd4, 5'd1, 5'd3), 1'b1);
        if ({f_stall_if, f_stall_id, f_flush_id} !== 3'b110) begin
            bad++; $display("FAIL lu_stall got=%b exp=110", {f_stall_if, f_stall_id, f_flush_id});
        end
        total++;
        next_cycle();
        feed(enc_r(7'h00, 5'd4, 5'd1, 5'd3), 1'b1);
        if ({f_stall_if, f_stall_id, f_mem_read} !== 3'b001) begin
            bad++; $display("FAIL lu_single_stall got=%b exp=001", {f_stall_if, f_stall_id, f_mem_read});
        end
        total++;
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_mem_read, f_fwd_a, f_fwd_b} !== 5'b00100) begin
            bad++; $display("FAIL lu_bubble_fwd got=%b exp=00100", {f_mem_read, f_fwd_a, f_fwd_b});
        end
        total++;
    endtask

    task automatic test_branch;
        do_reset();
        feed(enc_b(3'b000, 5'd1, 5'd2), 1'b1);
        next_cycle();
        feed(enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011), 1'b1);
        ex_eq = 1'b1;
        #1;
        if ({f_pc_sel, f_flush_id, f_stall_if} !== 4'b0110) begin
            bad++; $display("FAIL beq_taken got=%b exp=0110", {f_pc_sel, f_flush_id, f_stall_if});
        end
        total++;
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_pc_sel, f_flush_id} !== 3'b000) begin
            bad++; $display("FAIL beq_flush_once got=%b exp=000", {f_pc_sel, f_flush_id});
        end
        total++;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (f_wb_reg_write !== 1'b0) begin
                bad++; $display("FAIL beq_squashed_wb cycle=%0d got=%b exp=0", i, f_wb_reg_write);
            end
            total++;
        end

        do_reset();
        feed(enc_b(3'b101, 5'd1, 5'd2), 1'b1);
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_pc_sel, f_flush_id} !== 3'b011) begin
            bad++; $display("FAIL bge_taken got=%b exp=011", {f_pc_sel, f_flush_id});
        end
        total++;

        do_reset();
        feed(enc_b(3'b100, 5'd1, 5'd2), 1'b1);
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_pc_sel, f_flush_id} !== 3'b000) begin
            bad++; $display("FAIL blt_not_taken got=%b exp=000", {f_pc_sel, f_flush_id});
        end
        total++;
        ex_lt = 1'b1;
        #1;
        if ({f_pc_sel, f_flush_id} !== 3'b011) begin
            bad++; $display("FAIL blt_taken got=%b exp=011", {f_pc_sel, f_flush_id});
        end
        total++;

        do_reset();
        feed(enc_b(3'b111, 5'd1, 5'd2), 1'b1);
        next_cycle();
        feed(32'h0, 1'b0);
        ex_lt = 1'b1;
        #1;
        if ({f_pc_sel, f_flush_id} !== 3'b011) begin
            bad++; $display("FAIL bgeu_taken got=%b exp=011", {f_pc_sel, f_flush_id});
        end
        total++;
    endtask

    task automatic test_jalr;
        do_reset();
        feed(enc_i(12'd8, 5'd2, 3'b000, 5'd1, 7'b1100111), 1'b1);
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_pc_sel, f_flush_id, f_ex_alu_src} !== 4'b1011) begin
            bad++; $display("FAIL jalr_redirect got=%b exp=1011", {f_pc_sel, f_flush_id, f_ex_alu_src});
        end
        total++;
        next_cycle();
        next_cycle();
        if ({f_wb_reg_write, f_wb_mem_to_reg, f_wb_rd} !== 8'b1_10_00001) begin
            bad++; $display("FAIL jalr_wb got=%b exp=11000001", {f_wb_reg_write, f_wb_mem_to_reg, f_wb_rd});
        end
        total++;
    endtask

    task automatic test_illegal;
        do_reset();
        feed(32'h0000007F, 1'b1);
        if (f_illegal_id !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b exp=1", f_illegal_id); end
        total++;
        next_cycle();
        feed(enc_b(3'b010, 5'd1, 5'd2), 1'b1);
        if ({f_illegal_id, f_pc_sel, f_ex_alu_op, f_ex_alu_src} !== 8'b1_00_0000_0) begin
            bad++; $display("FAIL illegal_bubble_ex got=%b exp=10000000",
                            {f_illegal_id, f_pc_sel, f_ex_alu_op, f_ex_alu_src});
        end
        total++;
        next_cycle();
        feed(32'h0, 1'b0);
        if ({f_mem_read, f_mem_write, f_pc_sel, f_illegal_id} !== 5'b0) begin
            bad++; $display("FAIL illegal_no_effect got=%b exp=00000",
                            {f_mem_read, f_mem_write, f_pc_sel, f_illegal_id});
        end
        total++;
        next_cycle();
        if ({f_wb_reg_write, f_mem_write} !== 2'b00) begin
            bad++; $display("FAIL illegal_no_wb got=%b exp=00", {f_wb_reg_write, f_mem_write});
        end
        total++;
    endtask

    task automatic test_no_forwarding;
        do_reset();
        feed(enc_r(7'h00, 5'd3, 5'd2, 5'd1), 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            feed(enc_r(7'h00, 5'd1, 5'd1, 5'd2), 1'b1);
            if ({s_stall_if, s_stall_id, s_fwd_a, s_fwd_b} !== ((i < 2) ? 6'b110000 : 6'b000000)) begin
                bad++; $display("FAIL nf_raw_stall cycle=%0d got=%b exp=%b", i,
                                {s_stall_if, s_stall_id, s_fwd_a, s_fwd_b},
                                ((i < 2) ? 6'b110000 : 6'b000000));
            end
            total++;
        end
        next_cycle();
        feed(32'h0, 1'b0);
        if ({s_stall_if, s_fwd_a, s_fwd_b, s_ex_alu_op} !== 9'b0) begin
            bad++; $display("FAIL nf_consumer_ex got=%b exp=0", {s_stall_if, s_fwd_a, s_fwd_b, s_ex_alu_op});
        end
        total++;

        do_reset();
        feed(enc_r(7'h00, 5'd3, 5'd2, 5'd0), 1'b1);
        next_cycle();
        feed(enc_r(7'h00, 5'd0, 5'd0, 5'd4), 1'b1);
        if (s_stall_if !== 1'b0) begin bad++; $display("FAIL nf_x0_ex got=%b exp=0", s_stall_if); end
        total++;
        next_cycle();
        feed(32'h0, 1'b0);
        if ({s_stall_if, f_fwd_a, f_fwd_b} !== 5'b0) begin
            bad++; $display("FAIL x0_no_fwd got=%b exp=00000", {s_stall_if, f_fwd_a, f_fwd_b});
        end
        total++;

        do_reset();
        feed(enc_r(7'h00, 5'd3, 5'd2, 5'd1), 1'b1);
        next_cycle();
        feed(enc_b(3'b000, 5'd5, 5'd6), 1'b1);
        next_cycle();
        feed(enc_r(7'h00, 5'd1, 5'd1, 5'd7), 1'b1);
        if ({s_stall_if, s_stall_id, s_flush_id, s_pc_sel} !== 5'b11000) begin
            bad++; $display("FAIL nf_mem_hazard got=%b exp=11000", {s_stall_if, s_stall_id, s_flush_id, s_pc_sel});
        end
        total++;
        ex_eq = 1'b1;
        #1;
        if ({s_stall_if, s_stall_id, s_flush_id, s_pc_sel} !== 5'b00101) begin
            bad++; $display("FAIL nf_flush_wins got=%b exp=00101", {s_stall_if, s_stall_id, s_flush_id, s_pc_sel});
        end
        total++;
    endtask

    initial begin
        rst      = 1'b1;
        id_inst  = 32'h0;
        id_valid = 1'b0;
        ex_eq    = 1'b0;
        ex_lt    = 1'b0;
        ex_ltu   = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_jalr();
        test_illegal();
        test_no_forwarding();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle CONTROL decoder, for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Decodes the instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Resolves branches and jumps in EX.
- Detects load-use and RAW hazards; emits stall, flush and forwarding selects to the datapath.

Parameters:
FWD_EN, 1, 1 = forwarding paths in use; 0 = resolve every RAW hazard by stalling.
REG_AW, 5, register index width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
id_inst  in  32  instruction held in IF/ID.
id_valid  in  1  IF/ID holds a real instruction.
ex_eq  in  1  EX comparator: rs1 == rs2.
ex_lt  in  1  EX comparator: signed rs1 < rs2.
ex_ltu  in  1  EX comparator: unsigned rs1 < rs2.
ex_alu_op  out  4  ALU function for the EX instruction.
ex_alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate.
mem_read  out  1  MEM-stage load.
mem_write  out  1  MEM-stage store.
wb_reg_write  out  1  register-file write enable.
wb_mem_to_reg  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 PC+imm.
wb_rd  out  5  writeback register index.
pc_sel  out  2  next PC: 00 PC+4, 01 ex_pc+imm, 10 {alu[31:1],0}.
stall_if  out  1  hold PC.
stall_id  out  1  hold IF/ID.
flush_id  out  1  datapath clears IF/ID.
fwd_a  out  2  EX rs1 source: 00 register file, 01 MEM/WB, 10 EX/MEM.
fwd_b  out  2  EX rs2 source, same encoding as fwd_a.
illegal_id  out  1  unknown opcode currently in ID.

Behaviour:
- All logic on posedge clk; reset synchronous.
- Reset: every stage bundle becomes a bubble. All outputs 0; pc_sel = 00.
- Bubble definition: reg_write = 0, mem_read = 0, mem_write = 0, br_type = NONE, jump = 0, alu_op = ADD, rd = 0.
- Decode (combinational in ID), one bundle per opcode:
  - R-type: alu_op from funct3/funct7 (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND).
  - I-ALU: as R-type except SUB is not decodable.
  - LOAD, STORE: ADD.
  - BRANCH: br_type from funct3 (EQ NE LT GE LTU GEU). Undefined funct3 makes the instruction illegal.
  - JAL, JALR: mem_to_reg = 10.
  - LUI: alu_op = PASSB.
  - AUIPC: mem_to_reg = 11.
- Bubble inserted into ID/EX when: id_valid = 0, opcode illegal (illegal_id = 1 in that case), stall active, or flush active.
- Register use: rs1/rs2 usage flags are per opcode. LUI, AUIPC and JAL use neither; I-type, LOAD and JALR use rs1 only.
- Branch/jump (EX, combinational outputs):
  - Taken branch or JAL → pc_sel = 01. JALR → pc_sel = 10.
  - Taken means br_type matches the comparator: NE = !ex_eq, GE = !ex_lt, GEU = !ex_ltu.
  - When taken: flush_id = 1 and the ID/EX next value is a bubble. Two-cycle penalty.
- Load-use (FWD_EN = 1):
  - Condition: EX is a load, ex_rd != 0, and ex_rd matches a used rs of ID.
  - Response: stall_if = stall_id = 1 for exactly one cycle; bubble into ID/EX; EX/MEM advances normally.
- Forwarding (FWD_EN = 1), for rs1 and rs2 of EX independently:
  - 10 if the MEM instruction has reg_write, rd != 0 and rd == rs.
  - Otherwise 01 if the WB instruction matches the same way.
  - Otherwise 00. MEM has priority over WB.
- FWD_EN = 0:
  - fwd_a and fwd_b are always 00.
  - Stall while an EX or MEM instruction with reg_write and rd != 0 matches a used rs of ID.
  - The register file is write-through, so a WB match does not stall.
- Simultaneous flush and stall (FWD_EN = 0, hazard in MEM, taken branch in EX): flush wins and stall outputs are 0.
- x0 never causes a stall or forward.
- Reset asserted mid-stream: all in-flight bundles are discarded next cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode constants;
  - alu_op enum (ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9 PASSB=10);
  - br_type enum (NONE EQ NE LT GE LTU GEU);
  - mem_to_reg constants;
  - ctrl_bundle struct and the BUBBLE constant.
- One sub-module, inst_decode: the combinational ID decoder producing the bundle, rs-use flags and illegal.
- Hazard, forwarding and stage registers stay in pipe_ctrl.

Test Plan:
- Reset: rst = 1 for 2 cycles with id_valid = 1 → all outputs 0, pc_sel = 00; the first wb_reg_write appears 3 cycles after release with a valid add.
- FWD_EN = 1: add x1,x2,x3 then sub x4,x1,x5 → sub in EX shows fwd_a = 10 and fwd_b = 00; no stall. With one independent instruction between them, fwd_a = 01.
- lw x1,0(x2); add x3,x1,x4 → stall_if = stall_id = 1 for exactly 1 cycle; bubble reaches MEM with mem_read = 0; add in EX shows fwd_a = 01.
- beq with ex_eq = 1 → pc_sel = 01, flush_id = 1 for 1 cycle; the two younger addi never assert wb_reg_write. bge with ex_lt = 0 → taken; blt with ex_lt = 0 → pc_sel = 00, no flush.
- FWD_EN = 0: add x1,...; add x2,x1,x1 → exactly 2 stall cycles, fwd_a = fwd_b = 00 throughout. add x0,... followed by a consumer of x0 → no stall.
- id_inst = 0x0000007F → illegal_id = 1; no write, memory or PC effect downstream. jalr x1,8(x2) → pc_sel = 10, wb_mem_to_reg = 10.
